// File: rtl/onehot_drain_encoder.sv
// onehot_drain_encoder: latches a multi-hot vector and drains it as a
// stream of binary bit indices, lowest first, one per valid/ready transfer.
// Ports: clk, reset_n (async, active-low)
//   unencoded_input/in_valid/in_ready : vector intake (accepted only in IDLE)
//   encoded_output/out_valid/out_ready/out_last : index stream
//   zero_err : one-cycle pulse after a zero vector is accepted, only when
//              built with ONEHOT_DRAIN_ZERO_FLAG_EN; tied low otherwise
module onehot_drain_encoder #(
  parameter int OUTPUT_WIDTH = 5,
  parameter int INPUT_WIDTH  = 2**OUTPUT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [INPUT_WIDTH-1:0]  unencoded_input,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] encoded_output,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    zero_err
);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [INPUT_WIDTH-1:0]  pend_q;
  logic [INPUT_WIDTH-1:0]  pend_d;
  logic [INPUT_WIDTH-1:0]  low_bit;
  logic [OUTPUT_WIDTH-1:0] low_idx;
  logic                    single;
  logic                    accept;
  logic                    xfer;
  logic                    in_zero;

  // Two's-complement trick isolates the lowest set bit.
  assign low_bit = pend_q & (~pend_q + INPUT_WIDTH'(1));
  assign single  = (pend_q != '0) &&
                   ((pend_q & ~low_bit) == '0);

  // Scan high-to-low so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = INPUT_WIDTH-1; i >= 0; i--) begin
      if (pend_q[i]) begin
        low_idx = OUTPUT_WIDTH'(i);
      end
    end
  end

  assign in_zero = (unencoded_input == '0);
  assign accept  = in_valid && in_ready;
  assign xfer    = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !in_zero) begin
          pend_d  = unencoded_input;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer) begin
          pend_d = pend_q & ~low_bit;
          if (single) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // All outputs come from registers only.
  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == DRAIN);
  assign out_last       = out_valid && single;
  assign encoded_output = low_idx;

`ifdef ONEHOT_DRAIN_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= accept && in_zero;
    end
  end

  assign zero_err = zero_q;
`else
  assign zero_err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_drain_encoder.sv
// tb_onehot_drain_encoder: table vectors, hand sequences and random
// vectors checked against a bit-list queue model of the drain.
module tb_onehot_drain_encoder;

  logic        clk;
  logic        reset_n;
  logic [31:0] unencoded_input;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  encoded_output;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        zero_err;

  int n_checks;
  int n_fail;

`ifdef ONEHOT_DRAIN_ZERO_FLAG_EN
  localparam logic ZFLAG = 1'b1;
`else
  localparam logic ZFLAG = 1'b0;
`endif

  onehot_drain_encoder #(
    .OUTPUT_WIDTH(5),
    .INPUT_WIDTH (32)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .unencoded_input(unencoded_input),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .encoded_output (encoded_output),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .zero_err       (zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Present a vector for one edge; leaves in_valid low afterwards.
  task automatic load(input logic [31:0] vec);
    @(negedge clk);
    chk("load_in_ready", in_ready, 1);
    unencoded_input = vec;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Reference: the set bits of vec, ascending, must come out in order.
  task automatic drain(input logic [31:0] vec,
                       input int hold,
                       input bit rnd,
                       output int cnt,
                       output int first,
                       output int last);
    int q[$];
    int budget;
    int h;
    h = hold;
    budget = 0;
    cnt = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 32; i++)
      if (vec[i]) q.push_back(i);
    while (q.size() > 0 && budget < 1000) begin
      @(negedge clk);
      budget++;
      chk("out_valid", out_valid, 1);
      chk("in_ready_drain", in_ready, 0);
      chk("index", encoded_output, q[0]);
      chk("out_last", out_last, (q.size() == 1));
      if (h > 0) begin
        out_ready = 1'b0;
        h--;
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (out_ready) begin
        if (cnt == 0) first = q[0];
        last = q[0];
        cnt++;
        void'(q.pop_front());
      end
    end
    if (q.size() > 0) begin
      chk("drain_budget", q.size(), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask

  task automatic zero_vec();
    load(32'h0);
    @(negedge clk);
    chk("zero_out_valid", out_valid, 0);
    chk("zero_in_ready", in_ready, 1);
    chk("zero_err_pulse", zero_err, ZFLAG);
    @(negedge clk);
    chk("zero_err_end", zero_err, 0);
    chk("zero_out_valid2", out_valid, 0);
  endtask

  typedef struct {
    logic [31:0] vec;
    int          hold;
    int          n;
    int          first;
    int          last;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cnt;
    int first;
    int last;
    logic [31:0] v;

    n_checks = 0;
    n_fail = 0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    unencoded_input = '0;
    out_ready = 1'b1;

    tbl[0] = '{32'h0000_0100, 0, 1, 8, 8};
    tbl[1] = '{32'h8000_0005, 3, 3, 0, 31};
    tbl[2] = '{32'hFFFF_FFFF, 0, 32, 0, 31};
    tbl[3] = '{32'h0000_0001, 0, 1, 0, 0};
    tbl[4] = '{32'h8000_0000, 1, 1, 31, 31};
    tbl[5] = '{32'h0000_00F0, 2, 4, 4, 7};

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_index", encoded_output, 0);
    chk("rst_zero_err", zero_err, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      load(tbl[t].vec);
      drain(tbl[t].vec, tbl[t].hold, 1'b0, cnt, first, last);
      chk("tbl_count", cnt, tbl[t].n);
      chk("tbl_first", first, tbl[t].first);
      chk("tbl_last", last, tbl[t].last);
    end

    zero_vec();

    // Reset mid-drain after index 5 has transferred.
    load(32'h0000_00F0);
    @(negedge clk);
    chk("mid_idx4", encoded_output, 4);
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_idx5", encoded_output, 5);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_index", encoded_output, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    load(32'h1);
    drain(32'h1, 0, 1'b0, cnt, first, last);
    chk("post_rst_first", first, 0);

    // in_valid held high with another vector during the drain.
    load(32'h0000_0300);
    unencoded_input = 32'h0000_0021;
    in_valid = 1'b1;
    drain(32'h0000_0300, 1, 1'b0, cnt, first, last);
    chk("hold_a_count", cnt, 2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain(32'h0000_0021, 0, 1'b0, cnt, first, last);
    chk("hold_b_count", cnt, 2);
    chk("hold_b_last", last, 5);

    for (int r = 0; r < 40; r++) begin
      v = $urandom & $urandom;
      if (r % 10 == 3) v = 32'h0;
      if (v == 32'h0) begin
        zero_vec();
      end else begin
        load(v);
        drain(v, int'($urandom_range(0, 2)), 1'b1, cnt, first, last);
        chk("rnd_count", cnt, $countones(v));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
